// File: rtl/mac_divider.sv
// Iterative restoring divider: recovers Q and R from a packed MAC result word D
// and a factor B so that D = Q*B + R with R < B. It produces one quotient bit per clock.
module mac_divider #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OUT_WIDTH-1:0] D_IN,
    input  logic [WIDTH-1:0]     B_IN,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] Q_OUT,
    output logic [WIDTH-1:0]     R_OUT,
    output logic                 OVF,
    output logic                 DBZ
);

    localparam int CNT_W = $clog2(OUT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     rem;
    logic [OUT_WIDTH-1:0] shreg;
    logic [WIDTH-1:0]     divisor;

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH-1:0]     rem_diff;
    logic [WIDTH-1:0]     rem_next;
    logic                 q_bit;
    logic [OUT_WIDTH-1:0] shreg_next;
    logic                 accept;
    logic                 last_iter;

    // The shifted partial remainder carries one extra bit, so the compare is
    // exact. When it is >= divisor the difference is < divisor and fits WIDTH bits.
    always_comb begin
        rem_shift  = {rem, shreg[OUT_WIDTH-1]};
        q_bit      = (rem_shift >= {1'b0, divisor});
        rem_diff   = rem_shift[WIDTH-1:0] - divisor;
        rem_next   = q_bit ? rem_diff : rem_shift[WIDTH-1:0];
        shreg_next = {shreg[OUT_WIDTH-2:0], q_bit};
    end

    assign accept    = in_ready && in_valid;
    assign last_iter = (state == CALC) && (cnt == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: if (in_valid) state_next = (B_IN == '0) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rem     <= '0;
            shreg   <= '0;
            divisor <= '0;
            Q_OUT   <= '0;
            R_OUT   <= '0;
            OVF     <= 1'b0;
            DBZ     <= 1'b0;
        end else if (accept) begin
            shreg   <= D_IN;
            divisor <= B_IN;
            rem     <= '0;
            cnt     <= CNT_W'(OUT_WIDTH);
            // Divide by zero is resolved on the accepting edge; no iterations run.
            if (B_IN == '0) begin
                Q_OUT <= '1;
                R_OUT <= D_IN[WIDTH-1:0];
                OVF   <= 1'b0;
                DBZ   <= 1'b1;
            end
        end else if (state == CALC) begin
            rem   <= rem_next;
            shreg <= shreg_next;
            cnt   <= cnt - 1'b1;
            if (last_iter) begin
                Q_OUT <= shreg_next;
                R_OUT <= rem_next;
                OVF   <= |shreg_next[OUT_WIDTH-1:WIDTH];
                DBZ   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mac_divider.md
Name: mac_divider

Overview:
- Iterative restoring divider that inverts the multiply-accumulate pipeline.
- Takes a packed OUT_WIDTH-bit result word D and a WIDTH-bit factor B, and recovers quotient Q and remainder R such that D = Q*B + R with R < B.
- Sits downstream of the MAC path: it unpacks or checks MAC results back into the A and C operands.
- Uses valid/ready handshakes on the input and output sides. One bit of quotient is produced per clock.

Parameters:
- WIDTH, 8, width of the factor B and of the remainder R.
- OUT_WIDTH, 16, width of the dividend D and of the quotient Q. Must satisfy OUT_WIDTH >= 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  D_IN/B_IN are valid.
- in_ready  output  1  block can accept an operation.
- D_IN  input  OUT_WIDTH  dividend (MAC result word).
- B_IN  input  WIDTH  divisor.
- out_valid  output  1  result registers are valid.
- out_ready  input  1  consumer accepts the result.
- Q_OUT  output  OUT_WIDTH  quotient.
- R_OUT  output  WIDTH  remainder.
- OVF  output  1  quotient does not fit in WIDTH bits (Q_OUT[OUT_WIDTH-1:WIDTH] != 0).
- DBZ  output  1  divide by zero.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; counter cleared.
  - Q_OUT, R_OUT, OVF, DBZ and out_valid are 0.
  - in_ready = 1, since in_ready is decoded from state == IDLE only.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On an edge with in_valid high, latch D_IN into the shift register and B_IN into the divisor register.
    - If B_IN == 0, go to DONE. Otherwise go to CALC with counter = OUT_WIDTH and partial remainder = 0.
  - CALC:
    - in_ready = 0.
    - Each edge: shift {partial remainder, dividend} left by 1. Partial remainder is WIDTH+1 bits internally.
    - If the partial remainder is >= the divisor, subtract the divisor and shift in quotient bit 1; else shift in 0.
    - Decrement the counter. When the counter reaches 1 on an edge, that edge completes the last iteration and the state goes to DONE.
  - DONE:
    - out_valid = 1; outputs registered and stable.
    - On an edge with out_ready high, go to IDLE and clear out_valid.
    - Q_OUT, R_OUT, OVF and DBZ keep their last values until the next result loads.
- Latency:
  - Normal: out_valid rises exactly OUT_WIDTH clocks after the accepting edge (16 at defaults).
  - Divide by zero: out_valid rises 1 clock after the accepting edge.
- Divide by zero result: Q_OUT = all ones, R_OUT = D_IN[WIDTH-1:0], DBZ = 1, OVF = 0.
- Normal result: DBZ = 0; OVF set per its definition, registered together with Q_OUT.
- Throughput: at most one operation per OUT_WIDTH+2 clocks. No input is accepted while in CALC or DONE.
- Inputs are sampled only on the accepting edge. D_IN/B_IN changes afterwards have no effect.
- Backpressure: with out_ready low, DONE is held indefinitely. Outputs must not change.
- Reset mid-operation: aborts immediately and returns to IDLE with reset values. No partial result is ever presented.
- Arithmetic: all values unsigned. The subtract compare uses WIDTH+1 bits so the partial remainder never overflows.

Test Plan:
- D_IN=0x0A2F (200*13+7), B_IN=13 -> Q_OUT=0x00C8, R_OUT=0x07, OVF=0, DBZ=0, out_valid 16 clocks after accept.
- D_IN=0xFEFF (255*255+254), B_IN=0xFF -> Q_OUT=0x00FF, R_OUT=0xFE, OVF=0.
- D_IN=0xFFFF, B_IN=1 -> Q_OUT=0xFFFF, R_OUT=0x00, OVF=1.
- D_IN=0x1234, B_IN=0 -> DBZ=1, Q_OUT=0xFFFF, R_OUT=0x34, out_valid 1 clock after accept.
- Backpressure: result ready, out_ready held low 5 clocks -> outputs stable, in_ready=0. out_ready high -> in_ready=1 next clock. A new in_valid then computes correctly.
- Reset mid-operation: rst_n pulsed low 7 clocks into CALC -> out_valid=0, Q_OUT=R_OUT=0, in_ready=1. The next operation (0x0A2F/13) gives 0x00C8/0x07.
